// File: rtl/logicgate_sweep_pkg.sv
// Shared types and constants for the logic-gate sweep checker: FSM states,
// gate bit positions inside gate_in, and the golden truth table per vector.
package logicgate_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int N_VEC  = 4;
  localparam int N_GATE = 7;

  localparam int G_NOT  = 0;
  localparam int G_AND  = 1;
  localparam int G_OR   = 2;
  localparam int G_XOR  = 3;
  localparam int G_XNOR = 4;
  localparam int G_NAND = 5;
  localparam int G_NOR  = 6;

  // GOLDEN[idx] with A=idx[1], B=idx[0]
  localparam logic [N_VEC-1:0][N_GATE-1:0] GOLDEN = {7'h16, 7'h2C, 7'h2D, 7'h71};

endpackage

// File: rtl/logicgate_sweep_cmp.sv
// Combinational compare of the four captured gate vectors against GOLDEN,
// producing one sticky mismatch bit per gate output.
module logicgate_sweep_cmp
  import logicgate_sweep_pkg::*;
(
  input  logic [27:0] cap_flat,
  output logic [6:0]  mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_VEC; i++) begin
      mask = mask | (cap_flat[i*N_GATE +: N_GATE] ^ GOLDEN[i]);
    end
  end

endmodule

// File: rtl/logicgate_sweep_checker.sv
// Sweeps A/B through 00,01,10,11, captures the gate block outputs and checks
// them against the golden table. Optional fail_mask port: GATE_SWEEP_MASK_EN.
module logicgate_sweep_checker
  import logicgate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       gate_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt
`ifdef GATE_SWEEP_MASK_EN
  ,
  output logic [6:0]       fail_mask
`endif
);

  localparam int SC_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [SC_W-1:0]   settle_cnt;
  logic [6:0]        cap [N_VEC];
  logic [27:0]       cap_flat;
  logic [6:0]        cmp_mask;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign cap_flat = {cap[3], cap[2], cap[1], cap[0]};

  logicgate_sweep_cmp u_cmp (
    .cap_flat (cap_flat),
    .mask     (cmp_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    a_out     = idx[1];
    b_out     = idx[0];
    case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SC_W'(1)) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy      = 1'b1;
        state_nxt = (idx == 2'd3) ? CHECK : SETTLE;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx doubles as the A/B vector; clearing it in DONE returns a/b to 00 in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      settle_cnt <= '0;
      pass       <= 1'b0;
      pass_cnt   <= '0;
      for (int i = 0; i < N_VEC; i++) cap[i] <= '0;
`ifdef GATE_SWEEP_MASK_EN
      fail_mask  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          idx        <= '0;
          settle_cnt <= SC_W'(SETTLE_CYCLES);
          pass       <= 1'b0;
`ifdef GATE_SWEEP_MASK_EN
          fail_mask  <= '0;
`endif
        end
        SETTLE: settle_cnt <= settle_cnt - SC_W'(1);
        SAMPLE: begin
          cap[idx] <= gate_in;
          if (idx != 2'd3) begin
            idx        <= idx + 2'd1;
            settle_cnt <= SC_W'(SETTLE_CYCLES);
          end
        end
        CHECK: begin
          pass <= ~|cmp_mask;
          if (~|cmp_mask) pass_cnt <= sat_inc(pass_cnt);
`ifdef GATE_SWEEP_MASK_EN
          fail_mask <= cmp_mask;
`endif
        end
        DONE: idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logicgate_sweep_checker.sv
// Randomized self-checking bench: two checker instances (default and
// SETTLE_CYCLES=1/CNT_W=2) driven by a behavioural gate block with stuck bits.
module tb_logicgate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic [6:0] sa0, sa1;
  logic       glitch;
  logic       a_o [2], b_o [2], busy_o [2], done_o [2], pass_o [2];
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [6:0] gin [2];
`ifdef GATE_SWEEP_MASK_EN
  logic [6:0] fm [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_m [2];

  always #5 clk = ~clk;

  // {nor,nand,xnor,xor,or,and,not} from plain boolean operators
  function automatic logic [6:0] gates(input logic a, input logic b);
    return {~(a | b), ~(a & b), ~(a ^ b), a ^ b, a | b, a & b, ~a};
  endfunction

  function automatic logic [6:0] faulty(input logic a, input logic b);
    return (gates(a, b) & ~sa0) | sa1;
  endfunction

  function automatic logic [6:0] ref_mask(input logic [6:0] s0, input logic [6:0] s1);
    logic [6:0] m, g;
    m = '0;
    for (int v = 0; v < 4; v++) begin
      g = gates(v[1], v[0]);
      m = m | (((g & ~s0) | s1) ^ g);
    end
    return m;
  endfunction

  assign gin[0] = glitch ? 7'h7F : faulty(a_o[0], b_o[0]);
  assign gin[1] = glitch ? 7'h7F : faulty(a_o[1], b_o[1]);

  logicgate_sweep_checker u_dut0 (
    .clk (clk), .rst (rst), .start (start[0]), .gate_in (gin[0]),
    .a_out (a_o[0]), .b_out (b_o[0]), .busy (busy_o[0]), .done (done_o[0]),
    .pass (pass_o[0]), .pass_cnt (cnt0)
`ifdef GATE_SWEEP_MASK_EN
    , .fail_mask (fm[0])
`endif
  );

  logicgate_sweep_checker #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk (clk), .rst (rst), .start (start[1]), .gate_in (gin[1]),
    .a_out (a_o[1]), .b_out (b_o[1]), .busy (busy_o[1]), .done (done_o[1]),
    .pass (pass_o[1]), .pass_cnt (cnt1)
`ifdef GATE_SWEEP_MASK_EN
    , .fail_mask (fm[1])
`endif
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input int sel);
    return (sel != 0) ? int'(cnt1) : int'(cnt0);
  endfunction

  task automatic check_outputs(input int sel, input int v, input bit bsy, input bit dn,
                               input bit ps, input int cnt, input logic [6:0] msk);
    check_eq("a_out", int'(a_o[sel]), v / 2);
    check_eq("b_out", int'(b_o[sel]), v % 2);
    check_eq("busy", int'(busy_o[sel]), int'(bsy));
    check_eq("done", int'(done_o[sel]), int'(dn));
    check_eq("pass", int'(pass_o[sel]), int'(ps));
    check_eq("pass_cnt", cnt_of(sel), cnt);
`ifdef GATE_SWEEP_MASK_EN
    check_eq("fail_mask", int'(fm[sel]), int'(msk));
`else
    if (msk !== msk) check_eq("fail_mask_x", 0, 1);
`endif
  endtask

  // one sweep on instance sel; x1/x2 = extra start cycles, abort_k = rst cycle (0: none)
  task automatic run_sweep(input int sel, input logic [6:0] s0, input logic [6:0] s1,
                           input bit gl, input int x1, input int x2, input int abort_k);
    int s, maxc, new_cnt, ev, t_done;
    logic [6:0] em;
    bit ep, prev_pass;
    logic [6:0] prev_mask;
    s         = (sel != 0) ? 1 : 2;
    maxc      = (sel != 0) ? 3 : 255;
    t_done    = 4 * s + 6;
    em        = ref_mask(s0, s1);
    ep        = (em == 7'h00);
    new_cnt   = ep ? ((cnt_m[sel] < maxc) ? cnt_m[sel] + 1 : maxc) : cnt_m[sel];
    prev_pass = 1'b0;
    prev_mask = '0;
    sa0 = s0;
    sa1 = s1;
    glitch = gl;
    start[sel] = 1'b1;
    for (int k = 1; k <= 4 * s + 8; k++) begin
      tick();
      start[sel] = (k == x1 || k == x2);
      glitch = gl && !((k % (s + 1)) == 0 && k <= 4 * (s + 1));
      ev = (k <= 4 * s + 4) ? (k - 1) / (s + 1) : ((k <= t_done) ? 3 : 0);
      check_outputs(sel, ev, k <= t_done - 1, k == t_done,
                    (k >= t_done) ? ep : prev_pass,
                    (k >= t_done) ? new_cnt : cnt_m[sel],
                    (k >= t_done) ? em : prev_mask);
      if (k == abort_k) begin
        start[sel] = 1'b0;
        glitch = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        check_outputs(sel, 0, 1'b0, 1'b0, 1'b0, 0, 7'h00);
        sa0 = '0;
        sa1 = '0;
        return;
      end
    end
    cnt_m[sel] = new_cnt;
    glitch = 1'b0;
    sa0 = '0;
    sa1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel, s, x1, x2;
    logic [6:0] r0, r1;
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    sa0 = '0;
    sa1 = '0;
    glitch = 1'b0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    repeat (3) tick();
    rst = 1'b0;
    check_outputs(0, 0, 1'b0, 1'b0, 1'b0, 0, 7'h00);
    check_outputs(1, 0, 1'b0, 1'b0, 1'b0, 0, 7'h00);
    tick();

    // ideal block, then xor stuck at 0, then extra starts incl. the DONE cycle
    run_sweep(0, 7'h00, 7'h00, 1'b0, 0, 0, 0);
    run_sweep(0, 7'b0001000, 7'h00, 1'b0, 0, 0, 0);
    run_sweep(0, 7'h00, 7'h00, 1'b0, 3, 14, 0);
    run_sweep(0, 7'h00, 7'h00, 1'b1, 0, 0, 0);
    // reset during SETTLE of vector 2, then a clean sweep
    run_sweep(0, 7'h00, 7'h00, 1'b0, 0, 0, 8);
    tick();
    run_sweep(0, 7'h00, 7'h00, 1'b0, 0, 0, 0);

    // CNT_W=2 saturation with glitches outside SAMPLE, then a failing sweep
    for (int i = 0; i < 5; i++) run_sweep(1, 7'h00, 7'h00, 1'b1, 0, 0, 0);
    run_sweep(1, 7'h00, 7'b0000001, 1'b1, 0, 0, 0);

    for (int r = 0; r < 16; r++) begin
      sel = int'($urandom_range(0, 1));
      s   = (sel != 0) ? 1 : 2;
      r0  = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'h00;
      r1  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      x1  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 4 * s + 6)) : 0;
      x2  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 4 * s + 6)) : 0;
      run_sweep(sel, r0, r1, 1'($urandom_range(0, 1)), x1, x2, 0);
      if ($urandom_range(0, 1) != 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
